// File: rtl/Noc_parameters.sv
// Shared NoC/AXI field widths, flit markers and the control-flit builders
// used by both the packetizer and the receiver-side depacketizer.
package Noc_parameters;

    localparam int Noc_ID_X_Width     = 2;
    localparam int Noc_ID_Y_Width     = 2;
    localparam int Noc_VC_Channel     = 2;
    localparam int Noc_Data_Width     = 32;
    localparam int Noc_Flit_Width     = Noc_Data_Width + 2;
    localparam int Axi_TYPE_Bit       = 2;
    localparam int Axi_LEN_Bit        = 3;
    localparam int Axi_PACK_ORDER_Bit = 2;
    localparam int Noc_Mark_Bit       = 4;

    localparam logic [Noc_Mark_Bit-1:0] Noc_Head_H = 4'hA;
    localparam logic [Noc_Mark_Bit-1:0] Noc_Head_E = 4'h5;
    localparam logic [Noc_Mark_Bit-1:0] Noc_Tail_H = 4'hC;
    localparam logic [Noc_Mark_Bit-1:0] Noc_Tail_E = 4'h3;

    // Bits of the control payload carrying real fields; the rest is zero pad.
    localparam int Ctrl_Used_Bit = 2 * Noc_Mark_Bit + 2 * (Noc_ID_X_Width + Noc_ID_Y_Width)
                                 + Axi_TYPE_Bit + Axi_PACK_ORDER_Bit + Axi_LEN_Bit;
    localparam int Less_Byte     = Noc_Data_Width - Ctrl_Used_Bit;

    typedef logic [Noc_ID_X_Width-1:0]     noc_x_t;
    typedef logic [Noc_ID_Y_Width-1:0]     noc_y_t;
    typedef logic [Axi_TYPE_Bit-1:0]       axi_type_t;
    typedef logic [Axi_LEN_Bit-1:0]        axi_len_t;
    typedef logic [Axi_PACK_ORDER_Bit-1:0] pkt_order_t;
    typedef logic [Noc_Data_Width-1:0]     noc_data_t;
    typedef logic [Noc_Flit_Width-1:0]     flit_t;

    typedef enum logic [1:0] {PKT_IDLE, PKT_HEAD, PKT_BODY, PKT_TAIL} pkt_state_e;

    function automatic flit_t make_ctrl_flit(
        input logic [1:0]              flags,
        input logic [Noc_Mark_Bit-1:0] mark_h,
        input logic [Noc_Mark_Bit-1:0] mark_e,
        input noc_x_t                  src_x,
        input noc_y_t                  src_y,
        input noc_x_t                  dst_x,
        input noc_y_t                  dst_y,
        input axi_type_t               pkt_type,
        input pkt_order_t              order,
        input axi_len_t                len
    );
        return {flags, mark_h, src_x, src_y, dst_x, dst_y, pkt_type, order, len,
                mark_e, {Less_Byte{1'b0}}};
    endfunction

    function automatic flit_t make_head_flit(
        input noc_x_t     src_x,
        input noc_y_t     src_y,
        input noc_x_t     dst_x,
        input noc_y_t     dst_y,
        input axi_type_t  pkt_type,
        input pkt_order_t order,
        input axi_len_t   len
    );
        return make_ctrl_flit(2'b10, Noc_Head_H, Noc_Head_E, src_x, src_y, dst_x, dst_y,
                              pkt_type, order, len);
    endfunction

    function automatic flit_t make_tail_flit(
        input noc_x_t     src_x,
        input noc_y_t     src_y,
        input noc_x_t     dst_x,
        input noc_y_t     dst_y,
        input axi_type_t  pkt_type,
        input pkt_order_t order,
        input axi_len_t   len
    );
        return make_ctrl_flit(2'b01, Noc_Tail_H, Noc_Tail_E, src_x, src_y, dst_x, dst_y,
                              pkt_type, order, len);
    endfunction

endpackage

// File: rtl/Noc_flit_interface.sv
// Per-VC valid/ready flit channel between a local port and a router input.
interface Noc_flit_interface;
    import Noc_parameters::*;

    logic [Noc_VC_Channel-1:0]                     valid;
    logic [Noc_VC_Channel-1:0][Noc_Flit_Width-1:0] flit;
    logic [Noc_VC_Channel-1:0]                     ready;

    modport sender   (output valid, output flit, input ready);
    modport receiver (input valid, input flit, output ready);
endinterface

// File: rtl/noc_packetizer.sv
// Builds header/body/tail NoC packets from a request plus data beats on one VC.
// Latency: header one cycle after request accept; body beats pass through combinationally.
// Backpressure: VC ready stalls any state cycle-for-cycle; header/tail held until accepted.
module noc_packetizer
    import Noc_parameters::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID   = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID   = '0,
    parameter int unsigned               VC_SEL = 0
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [Noc_ID_X_Width-1:0]     req_dest_x,
    input  logic [Noc_ID_Y_Width-1:0]     req_dest_y,
    input  logic [Axi_TYPE_Bit-1:0]       req_type,
    input  logic [Axi_LEN_Bit-1:0]        req_len,
    input  logic                          dat_valid,
    output logic                          dat_ready,
    input  logic [Noc_Data_Width-1:0]     dat,
    Noc_flit_interface.sender             noc_sender_if,
    output logic                          busy,
    output logic                          pkt_sent
);

    localparam int VC_IW = (Noc_VC_Channel > 1) ? $clog2(Noc_VC_Channel) : 1;
    localparam logic [VC_IW-1:0] VC_IDX = VC_IW'(VC_SEL);

    pkt_state_e state;
    axi_len_t   beat_cnt;
    pkt_order_t order;
    noc_x_t     dst_x_q;
    noc_y_t     dst_y_q;
    axi_type_t  type_q;
    axi_len_t   len_q;
    flit_t      ctrl_flit_q;
    logic       vc_ready;

    assign vc_ready = noc_sender_if.ready[VC_IDX];

    // ctrl_flit_q is rebuilt on entry to HEAD and TAIL so both control flits come from a flop.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state       <= PKT_IDLE;
            beat_cnt    <= '0;
            order       <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            type_q      <= '0;
            len_q       <= '0;
            ctrl_flit_q <= '0;
        end else begin
            case (state)
                PKT_IDLE: begin
                    if (req_valid) begin
                        dst_x_q     <= req_dest_x;
                        dst_y_q     <= req_dest_y;
                        type_q      <= req_type;
                        len_q       <= req_len;
                        beat_cnt    <= req_len;
                        ctrl_flit_q <= make_head_flit(X_ID, Y_ID, req_dest_x, req_dest_y,
                                                      req_type, order, req_len);
                        state       <= PKT_HEAD;
                    end
                end
                PKT_HEAD: begin
                    if (vc_ready) begin
                        state <= PKT_BODY;
                    end
                end
                PKT_BODY: begin
                    if (dat_valid && vc_ready) begin
                        if (beat_cnt == '0) begin
                            ctrl_flit_q <= make_tail_flit(X_ID, Y_ID, dst_x_q, dst_y_q,
                                                          type_q, order, len_q);
                            state       <= PKT_TAIL;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                PKT_TAIL: begin
                    if (vc_ready) begin
                        order <= order + 1'b1;
                        state <= PKT_IDLE;
                    end
                end
                default: state <= PKT_IDLE;
            endcase
        end
    end

    always_comb begin
        noc_sender_if.valid = '0;
        noc_sender_if.flit  = '0;
        case (state)
            PKT_HEAD, PKT_TAIL: begin
                noc_sender_if.valid[VC_IDX] = 1'b1;
                noc_sender_if.flit[VC_IDX]  = ctrl_flit_q;
            end
            PKT_BODY: begin
                noc_sender_if.valid[VC_IDX] = dat_valid;
                noc_sender_if.flit[VC_IDX]  = {2'b00, dat};
            end
            default: ;
        endcase
    end

    assign req_ready = (state == PKT_IDLE);
    assign dat_ready = (state == PKT_BODY) && vc_ready;
    assign busy      = (state != PKT_IDLE);
    assign pkt_sent  = (state == PKT_TAIL) && vc_ready;

endmodule

// File: tb/tb_noc_packetizer.sv
module tb_noc_packetizer;
    import Noc_parameters::*;

    localparam logic [1:0] XID = 2'd1;
    localparam logic [1:0] YID = 2'd3;

    logic        noc_clk;
    logic        noc_rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest_x;
    logic [1:0]  req_dest_y;
    logic [1:0]  req_type;
    logic [2:0]  req_len;
    logic        dat_valid;
    logic        dat_ready;
    logic [31:0] dat;
    logic        busy;
    logic        pkt_sent;

    Noc_flit_interface nif ();

    noc_packetizer #(.X_ID(XID), .Y_ID(YID), .VC_SEL(1)) dut (
        .noc_clk      (noc_clk),
        .noc_rst      (noc_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dest_x   (req_dest_x),
        .req_dest_y   (req_dest_y),
        .req_type     (req_type),
        .req_len      (req_len),
        .dat_valid    (dat_valid),
        .dat_ready    (dat_ready),
        .dat          (dat),
        .noc_sender_if(nif.sender),
        .busy         (busy),
        .pkt_sent     (pkt_sent)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    int total, bad;
    int cyc, req_cyc, other_bad, hold_bad, vf_bad, rr_bad;
    logic [33:0] mf[$];
    int          mc[$];
    int          sc[$];
    logic [31:0] dq[$];
    bit          gq[$];
    bit          rq[$];
    bit          gq_pend[$];
    bit          rq_pend[$];
    logic [1:0]  exp_order;

    function automatic logic [33:0] exp_ctrl(input bit tail, input logic [1:0] dx,
                                             input logic [1:0] dy, input logic [1:0] ty,
                                             input logic [1:0] ord, input logic [2:0] ln);
        logic [3:0] h, e;
        h = tail ? 4'hC : 4'hA;
        e = tail ? 4'h3 : 4'h5;
        return {tail ? 2'b01 : 2'b10, h, XID, YID, dx, dy, ty, ord, ln, e, 9'd0};
    endfunction

    // Monitor: records accepted flits, pkt_sent pulses and protocol violations.
    initial begin
        logic        prev_stall;
        logic [33:0] prev_flit;
        prev_stall = 1'b0;
        prev_flit  = '0;
        cyc = 0; req_cyc = -1; other_bad = 0; hold_bad = 0; vf_bad = 0; rr_bad = 0;
        forever begin
            @(negedge noc_clk);
            cyc++;
            if (noc_rst === 1'b0) begin
                if (nif.valid[0] !== 1'b0 || nif.flit[0] !== 34'd0) other_bad++;
                if (prev_stall && (nif.valid[1] !== 1'b1 || nif.flit[1] !== prev_flit)) hold_bad++;
                prev_stall = nif.valid[1] && !nif.ready[1] && (nif.flit[1][33:32] != 2'b00);
                prev_flit  = nif.flit[1];
                if (dat_ready && nif.valid[1] !== dat_valid) vf_bad++;
                if (busy && req_ready) rr_bad++;
                if (nif.valid[1] && nif.ready[1]) begin
                    mf.push_back(nif.flit[1]);
                    mc.push_back(cyc);
                end
                if (pkt_sent) sc.push_back(cyc);
                if (req_valid && req_ready) req_cyc = cyc;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Data source: presents dq beats in order, gapped by gq, flushed by reset.
    initial begin
        bit fire, g;
        int dptr, gptr;
        dptr = 0; gptr = 0;
        dat_valid = 1'b0;
        dat = '0;
        forever begin
            @(negedge noc_clk);
            fire = dat_valid && dat_ready;
            @(posedge noc_clk);
            #1;
            if (noc_rst) dptr = dq.size();
            else if (fire) dptr++;
            g = 1'b0;
            if (gptr < gq.size()) begin
                g = gq[gptr];
                gptr++;
            end
            dat_valid = (dptr < dq.size()) && !g;
            dat = (dptr < dq.size()) ? dq[dptr] : 32'd0;
        end
    end

    initial begin
        int rptr;
        rptr = 0;
        nif.ready = 2'b11;
        forever begin
            @(posedge noc_clk);
            #1;
            if (rptr < rq.size()) begin
                nif.ready[1] = rq[rptr];
                rptr++;
            end else begin
                nif.ready[1] = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Issues one request, arms stall/gap patterns from the header cycle, waits for pkt_sent.
    task automatic send_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] ty,
                            input logic [2:0] ln, output int t);
        bit ok;
        int n0;
        @(posedge noc_clk); #1;
        req_valid = 1'b1; req_dest_x = dx; req_dest_y = dy; req_type = ty; req_len = ln;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge noc_clk); #1;
            if (req_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) begin total++; bad++; $display("FAIL req_accept timeout"); end
        t = req_cyc;
        foreach (rq_pend[i]) rq.push_back(rq_pend[i]);
        foreach (gq_pend[i]) gq.push_back(gq_pend[i]);
        rq_pend.delete();
        gq_pend.delete();
        n0 = sc.size();
        @(posedge noc_clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge noc_clk); #1;
            if (sc.size() > n0) ok = 1'b1;
        end
        if (!ok) begin total++; bad++; $display("FAIL pkt_sent timeout"); end
    endtask

    task automatic test_reset();
        noc_rst = 1'b1;
        repeat (3) @(posedge noc_clk);
        @(negedge noc_clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        total++; if (dat_ready !== 1'b0) begin bad++; $display("FAIL rst_dat_ready got %b exp 0", dat_ready); end
        total++; if (nif.valid !== 2'b00) begin bad++; $display("FAIL rst_valid got %b exp 00", nif.valid); end
        total++; if (nif.flit[0] !== 34'd0) begin bad++; $display("FAIL rst_flit0 got %h exp 0", nif.flit[0]); end
        total++; if (nif.flit[1] !== 34'd0) begin bad++; $display("FAIL rst_flit1 got %h exp 0", nif.flit[1]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", busy); end
        total++; if (pkt_sent !== 1'b0) begin bad++; $display("FAIL rst_pkt_sent got %b exp 0", pkt_sent); end
        @(posedge noc_clk); #1;
        noc_rst = 1'b0;
        @(negedge noc_clk); #1;
    endtask

    task automatic test_basic();
        logic [33:0] e[$];
        int ec[$];
        int b, sb, t;
        b = mf.size(); sb = sc.size();
        dq.push_back(32'hAAAA_0001); dq.push_back(32'hBBBB_0002); dq.push_back(32'hCCCC_0003);
        send_pkt(2'd2, 2'd1, 2'd1, 3'd2, t);
        e = '{exp_ctrl(0, 2'd2, 2'd1, 2'd1, 2'd0, 3'd2), {2'b00, 32'hAAAA_0001},
              {2'b00, 32'hBBBB_0002}, {2'b00, 32'hCCCC_0003}, exp_ctrl(1, 2'd2, 2'd1, 2'd1, 2'd0, 3'd2)};
        ec = '{t + 1, t + 2, t + 3, t + 4, t + 5};
        total++; if (mf.size() - b !== 5) begin bad++; $display("FAIL basic_count got %0d exp 5", mf.size() - b); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b + i >= mf.size() || mf[b + i] !== e[i] || mc[b + i] !== ec[i]) begin
                bad++;
                $display("FAIL basic_flit[%0d] got %h@%0d exp %h@%0d", i,
                         (b + i < mf.size()) ? mf[b + i] : 34'd0, (b + i < mc.size()) ? mc[b + i] : -1, e[i], ec[i]);
            end
        end
        total++; if (sc.size() - sb !== 1 || sc[sb] !== t + 5) begin
            bad++; $display("FAIL basic_pkt_sent got %0d pulses exp 1 at %0d", sc.size() - sb, t + 5);
        end
        exp_order++;
    endtask

    task automatic test_stall();
        logic [33:0] e[$];
        int ec[$];
        int b, t;
        b = mf.size();
        for (int i = 0; i < 4; i++) dq.push_back(32'hD000_0000 + i);
        rq_pend = '{0, 0, 0, 1, 1, 0, 0};
        send_pkt(2'd3, 2'd0, 2'd2, 3'd3, t);
        e = '{exp_ctrl(0, 2'd3, 2'd0, 2'd2, exp_order, 3'd3), {2'b00, 32'hD000_0000},
              {2'b00, 32'hD000_0001}, {2'b00, 32'hD000_0002}, {2'b00, 32'hD000_0003},
              exp_ctrl(1, 2'd3, 2'd0, 2'd2, exp_order, 3'd3)};
        ec = '{t + 4, t + 5, t + 8, t + 9, t + 10, t + 11};
        total++; if (mf.size() - b !== 6) begin bad++; $display("FAIL stall_count got %0d exp 6", mf.size() - b); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (b + i >= mf.size() || mf[b + i] !== e[i] || mc[b + i] !== ec[i]) begin
                bad++;
                $display("FAIL stall_flit[%0d] got %h@%0d exp %h@%0d", i,
                         (b + i < mf.size()) ? mf[b + i] : 34'd0, (b + i < mc.size()) ? mc[b + i] : -1, e[i], ec[i]);
            end
        end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL stall_hold got %0d unstable cycles exp 0", hold_bad); end
        exp_order++;
    endtask

    task automatic test_gaps();
        logic [33:0] e[$];
        int ec[$];
        int b, t, nbody;
        b = mf.size();
        dq.push_back(32'hE000_0010); dq.push_back(32'hE000_0011); dq.push_back(32'hE000_0012);
        gq_pend = '{0, 1, 0, 1, 1};
        send_pkt(2'd0, 2'd3, 2'd0, 3'd2, t);
        e = '{exp_ctrl(0, 2'd0, 2'd3, 2'd0, exp_order, 3'd2), {2'b00, 32'hE000_0010},
              {2'b00, 32'hE000_0011}, {2'b00, 32'hE000_0012}, exp_ctrl(1, 2'd0, 2'd3, 2'd0, exp_order, 3'd2)};
        ec = '{t + 1, t + 3, t + 6, t + 7, t + 8};
        nbody = 0;
        for (int i = b; i < mf.size(); i++) if (mf[i][33:32] == 2'b00) nbody++;
        total++; if (nbody !== 3) begin bad++; $display("FAIL gaps_body_count got %0d exp 3", nbody); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b + i >= mf.size() || mf[b + i] !== e[i] || mc[b + i] !== ec[i]) begin
                bad++;
                $display("FAIL gaps_flit[%0d] got %h@%0d exp %h@%0d", i,
                         (b + i < mf.size()) ? mf[b + i] : 34'd0, (b + i < mc.size()) ? mc[b + i] : -1, e[i], ec[i]);
            end
        end
        total++; if (vf_bad !== 0) begin bad++; $display("FAIL gaps_valid_follow got %0d exp 0", vf_bad); end
        exp_order++;
    endtask

    task automatic test_wrap();
        int b, t, last_tail;
        logic [33:0] h, tl;
        @(posedge noc_clk); #1; noc_rst = 1'b1;
        @(posedge noc_clk); #1; noc_rst = 1'b0;
        @(negedge noc_clk); #1;
        exp_order = 2'd0;
        last_tail = -1;
        h = '0;
        for (int k = 0; k < 5; k++) begin
            b = mf.size();
            dq.push_back(32'hC0DE_0000 + k);
            send_pkt(2'd0, 2'd2, 2'd3, 3'd0, t);
            h  = (mf.size() > b)     ? mf[b]     : 34'd0;
            tl = (mf.size() > b + 2) ? mf[b + 2] : 34'd0;
            total++; if (mf.size() - b !== 3) begin bad++; $display("FAIL wrap%0d_count got %0d exp 3", k, mf.size() - b); end
            total++; if (h !== exp_ctrl(0, 2'd0, 2'd2, 2'd3, exp_order, 3'd0)) begin
                bad++; $display("FAIL wrap%0d_head got %h exp %h", k, h, exp_ctrl(0, 2'd0, 2'd2, 2'd3, exp_order, 3'd0));
            end
            total++; if (tl !== exp_ctrl(1, 2'd0, 2'd2, 2'd3, exp_order, 3'd0)) begin
                bad++; $display("FAIL wrap%0d_tail got %h exp %h", k, tl, exp_ctrl(1, 2'd0, 2'd2, 2'd3, exp_order, 3'd0));
            end
            if (k > 0) begin
                total++; if (t !== last_tail + 1) begin bad++; $display("FAIL wrap%0d_bubble got req@%0d exp %0d", k, t, last_tail + 1); end
            end
            last_tail = (sc.size() > 0) ? sc[sc.size() - 1] : -1;
            exp_order++;
        end
        total++; if (h[17:16] !== 2'b00) begin bad++; $display("FAIL wrap_last_order got %b exp 00", h[17:16]); end
        total++; if (rr_bad !== 0) begin bad++; $display("FAIL wrap_req_ready_busy got %0d exp 0", rr_bad); end
    endtask

    task automatic test_maxlen();
        int b, t;
        logic [33:0] e;
        b = mf.size();
        for (int i = 0; i < 8; i++) dq.push_back(32'h5A00_0000 | i);
        send_pkt(2'd1, 2'd1, 2'd2, 3'd7, t);
        total++; if (mf.size() - b !== 10) begin bad++; $display("FAIL maxlen_count got %0d exp 10", mf.size() - b); end
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      e = exp_ctrl(0, 2'd1, 2'd1, 2'd2, exp_order, 3'd7);
            else if (i == 9) e = exp_ctrl(1, 2'd1, 2'd1, 2'd2, exp_order, 3'd7);
            else             e = {2'b00, 32'h5A00_0000 | (i - 1)};
            total++;
            if (b + i >= mf.size() || mf[b + i] !== e || mc[b + i] !== t + 1 + i) begin
                bad++;
                $display("FAIL maxlen_flit[%0d] got %h@%0d exp %h@%0d", i,
                         (b + i < mf.size()) ? mf[b + i] : 34'd0, (b + i < mc.size()) ? mc[b + i] : -1, e, t + 1 + i);
            end
        end
        total++; if (mf.size() > b + 9 && (mf[b][15:13] !== 3'b111 || mf[b + 9][15:13] !== 3'b111)) begin
            bad++; $display("FAIL maxlen_len_field got %b/%b exp 111/111", mf[b][15:13], mf[b + 9][15:13]);
        end
        exp_order++;
    endtask

    task automatic test_reset_mid();
        int b, sb, t, ntail;
        bit ok;
        b = mf.size(); sb = sc.size();
        for (int i = 0; i < 4; i++) dq.push_back(32'hF000_0000 + i);
        @(posedge noc_clk); #1;
        req_valid = 1'b1; req_dest_x = 2'd2; req_dest_y = 2'd2; req_type = 2'd1; req_len = 3'd3;
        @(negedge noc_clk); #1;
        @(posedge noc_clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge noc_clk); #1;
            if (mf.size() >= b + 3) ok = 1'b1;
        end
        if (!ok) begin total++; bad++; $display("FAIL rmid_body timeout"); end
        @(posedge noc_clk); #1; noc_rst = 1'b1;
        @(negedge noc_clk); #1;
        @(negedge noc_clk); #1;
        total++; if (nif.valid !== 2'b00) begin bad++; $display("FAIL rmid_valid got %b exp 00", nif.valid); end
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_idle got req_ready=%b busy=%b exp 1/0", req_ready, busy);
        end
        ntail = 0;
        for (int i = b; i < mf.size(); i++) if (mf[i][33:32] == 2'b01) ntail++;
        total++; if (ntail !== 0 || sc.size() !== sb) begin
            bad++; $display("FAIL rmid_no_tail got %0d tails %0d pulses exp 0/0", ntail, sc.size() - sb);
        end
        @(posedge noc_clk); #1; noc_rst = 1'b0;
        @(negedge noc_clk); #1;
        exp_order = 2'd0;
        b = mf.size();
        dq.push_back(32'h1234_5678);
        send_pkt(XID, YID, 2'd3, 3'd0, t);
        total++; if (mf.size() - b !== 3) begin bad++; $display("FAIL rmid_fresh_count got %0d exp 3", mf.size() - b); end
        total++; if (mf.size() > b + 2 && (mf[b] !== exp_ctrl(0, XID, YID, 2'd3, 2'd0, 3'd0)
                                        || mf[b + 1] !== {2'b00, 32'h1234_5678}
                                        || mf[b + 2] !== exp_ctrl(1, XID, YID, 2'd3, 2'd0, 3'd0))) begin
            bad++; $display("FAIL rmid_fresh_pkt got %h %h %h exp %h", mf[b], mf[b + 1], mf[b + 2],
                            exp_ctrl(0, XID, YID, 2'd3, 2'd0, 3'd0));
        end
    endtask

    initial begin
        total = 0; bad = 0; exp_order = 2'd0;
        noc_rst = 1'b1; req_valid = 1'b0;
        req_dest_x = '0; req_dest_y = '0; req_type = '0; req_len = '0;
        test_reset();
        test_basic();
        test_stall();
        test_gaps();
        test_wrap();
        test_maxlen();
        test_reset_mid();
        total++; if (other_bad !== 0) begin bad++; $display("FAIL other_vc_idle got %0d exp 0", other_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
